flags_branch_unit: RTL
======================

Name: flags_branch_unit

Overview:
Consumer end of the ALU result interface. It registers the NZCV flags the ALU produces and evaluates 4-bit branch condition codes against them. It owns the program counter and sequences fetch-address updates: increment, conditional branch, interrupt entry and interrupt return. On interrupt entry it saves PC and flags to a small stack, and restores both on return.

Parameters:
RESET_VECTOR, 16'h0000, PC value loaded on reset.
IRQ_VECTOR, 16'h0010, PC value loaded on interrupt entry.
SAVE_DEPTH, 2, number of nested {PC, NZCV} save entries (1..4).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
alu_flags_i  in  4  ALU flags, bit order [3]N [2]Z [1]C [0]V.
flags_we  in  1  latch alu_flags_i into the flag register this cycle.
cond  in  4  condition code of the current branch instruction.
branch_req  in  1  current instruction is a conditional branch.
branch_target  in  16  absolute target address.
irq  in  1  level-sensitive interrupt request.
reti  in  1  current instruction is return-from-interrupt.
stall  in  1  freeze all state this cycle.
pc_out  out  16  current fetch address (registered).
flags_q  out  4  registered NZCV.
branch_taken  out  1  combinational: branch_req && condition true && state==RUN.
irq_ack  out  1  one-cycle pulse on the interrupt-accept edge.
isr_depth  out  3  number of occupied save entries.

Behaviour:
- Reset (async, rst_n=0): pc_out=RESET_VECTOR, flags_q=0, isr_depth=0, irq_ack=0, state=RUN, stack contents don't-care.
- Condition table (uses flags_q):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
- FSM states:
  - RUN: normal operation.
  - VECTOR: 1-cycle bubble after interrupt entry.
  - RESTORE: 1-cycle bubble after reti.
- In VECTOR and RESTORE: branch_req, reti, irq and flags_we are ignored, pc_out<=pc_out+1, and the next state is RUN.
- RUN priority per unstalled cycle, highest first:
  1. reti with isr_depth>0: pop stack, pc_out<=saved PC, flags_q<=saved flags, depth-1, go to RESTORE.
  2. irq with isr_depth<SAVE_DEPTH: push {pc_out+1, flags_q}, pc_out<=IRQ_VECTOR, depth+1, irq_ack=1 next cycle, go to VECTOR.
  3. branch_taken: pc_out<=branch_target.
  4. Otherwise: pc_out<=pc_out+1.
- flags_we in RUN loads flags_q, except when reti pops this cycle (the restore wins).
- An irq that is accepted still allows this cycle's flags_we. The pushed value is the pre-update flags_q.
- Wrap-around: pc 16'hFFFF+1 = 16'h0000. branch_target is used unmodified.
- Boundaries:
  - reti with depth 0 is treated as a no-op plus increment.
  - irq while depth==SAVE_DEPTH is held off until a reti frees an entry; there is no loss or error while irq stays high.
  - reti and irq in the same cycle: reti wins, and irq is re-evaluated after RESTORE.
- stall=1: all registers, including the FSM, stack and flags, hold. irq_ack is forced 0. branch_taken is still computed.
- Reset asserted mid-VECTOR/RESTORE returns immediately to the reset values.

Optional Feature:
FLAG_FORWARD_EN:
- Defined: condition evaluation uses alu_flags_i instead of flags_q when flags_we=1 in the same cycle, allowing a compare and branch in one cycle.
- Undefined: condition evaluation always uses flags_q, so a branch sees flags from a prior flag-writing instruction.

Decomposition:
- Package cpu_pkg:
  - cond_e enum (EQ..NV).
  - flag bit index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
  - fbu_state_e {RUN, VECTOR, RESTORE}.
- One sub-module, cond_eval: purely combinational (flags, cond) -> taken. It is reusable by a future predication unit.
- The stack stays inline as an array plus depth counter.

Test Plan:
- Reset: pc_out=0000, flags_q=0, depth=0. Six unstalled cycles, no requests -> pc_out=0006.
- Flags 4'b0100, cond=0 (EQ), branch_req=1, target 0x0040 -> branch_taken=1, pc_out=0x0040 next cycle. cond=1 (NE) -> pc+1.
- Flags N=1,V=0: GE not taken, LT taken. pc=0xFFFF, no branch -> pc=0x0000.
- pc=0x0020, flags=4'b0010, irq=1 -> irq_ack pulse, pc=0x0010, depth=1, one VECTOR cycle. Later reti -> pc=0x0021, flags_q=4'b0010, depth=0.
- SAVE_DEPTH=2, irq held through two entries -> depth=2. A third entry is held off until reti. reti+irq in the same cycle -> reti first, irq accepted after RESTORE.
- stall=1 for 3 cycles during VECTOR -> all outputs frozen. With FLAG_FORWARD_EN: flags_we=1, alu_flags_i Z=1, cond EQ same cycle -> taken. Without the macro -> not taken.

Source files
------------

// File: rtl/flags_branch_unit_pkg.sv
// Shared CPU definitions: condition codes, NZCV bit positions and
// the flags/branch unit state encoding.
package cpu_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    VECTOR  = 2'd1,
    RESTORE = 2'd2
  } fbu_state_e;

endpackage

// File: rtl/flags_branch_unit_cond_eval.sv
// Combinational condition-code evaluator: (NZCV flags, 4-bit cond) -> taken.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       taken
);

  logic n_s, z_s, c_s, v_s;

  assign n_s = flags[N_BIT];
  assign z_s = flags[Z_BIT];
  assign c_s = flags[C_BIT];
  assign v_s = flags[V_BIT];

  // Condition table lookup
  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      EQ:      taken = z_s;
      NE:      taken = ~z_s;
      CS:      taken = c_s;
      CC:      taken = ~c_s;
      MI:      taken = n_s;
      PL:      taken = ~n_s;
      VS:      taken = v_s;
      VC:      taken = ~v_s;
      HI:      taken = c_s & ~z_s;
      LS:      taken = ~c_s | z_s;
      GE:      taken = (n_s == v_s);
      LT:      taken = (n_s != v_s);
      GT:      taken = ~z_s & (n_s == v_s);
      LE:      taken = z_s | (n_s != v_s);
      AL:      taken = 1'b1;
      NV:      taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flags_branch_unit.sv
// Flag register, branch resolution, PC sequencing and interrupt save/restore.
// Optional macro FLAG_FORWARD_EN: evaluate conditions on same-cycle ALU flags.
module flags_branch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] IRQ_VECTOR   = 16'h0010,
  parameter int          SAVE_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  alu_flags_i,
  input  logic        flags_we,
  input  logic [3:0]  cond,
  input  logic        branch_req,
  input  logic [15:0] branch_target,
  input  logic        irq,
  input  logic        reti,
  input  logic        stall,
  output logic [15:0] pc_out,
  output logic [3:0]  flags_q,
  output logic        branch_taken,
  output logic        irq_ack,
  output logic [2:0]  isr_depth
);

  localparam logic [2:0] MAX_DEPTH = 3'(SAVE_DEPTH);

  fbu_state_e  state_r, state_s;
  logic [15:0] pc_r, pc_s;
  logic [3:0]  flags_r, flags_s;
  logic [2:0]  depth_r, depth_s;
  logic        ack_r, ack_s;
  logic        push_s;
  logic [19:0] stack_r [0:3];
  logic [1:0]  pop_idx_s;
  logic [3:0]  eval_flags_s;
  logic        cond_true_s;

`ifdef FLAG_FORWARD_EN
  assign eval_flags_s = flags_we ? alu_flags_i : flags_r;
`else
  assign eval_flags_s = flags_r;
`endif

  cond_eval u_cond_eval (
    .flags (eval_flags_s),
    .cond  (cond),
    .taken (cond_true_s)
  );

  assign branch_taken = branch_req & cond_true_s & (state_r == RUN);
  assign pop_idx_s    = depth_r[1:0] - 2'd1;

  // Next-state, PC, flag and stack-depth sequencing
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    flags_s = flags_r;
    depth_s = depth_r;
    ack_s   = 1'b0;
    push_s  = 1'b0;
    if (stall) begin
      ack_s = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (reti && (depth_r != 3'd0)) begin
            pc_s    = stack_r[pop_idx_s][19:4];
            flags_s = stack_r[pop_idx_s][3:0];
            depth_s = depth_r - 3'd1;
            state_s = RESTORE;
          end else begin
            if (flags_we) begin
              flags_s = alu_flags_i;
            end else begin
              flags_s = flags_r;
            end
            if (irq && (depth_r < MAX_DEPTH)) begin
              push_s  = 1'b1;
              pc_s    = IRQ_VECTOR;
              depth_s = depth_r + 3'd1;
              ack_s   = 1'b1;
              state_s = VECTOR;
            end else if (branch_taken) begin
              pc_s = branch_target;
            end else begin
              pc_s = pc_r + 16'd1;
            end
          end
        end
        VECTOR, RESTORE: begin
          pc_s    = pc_r + 16'd1;
          state_s = RUN;
        end
        default: begin
          pc_s    = pc_r + 16'd1;
          state_s = RUN;
        end
      endcase
    end
  end

  // Architectural state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      pc_r    <= RESET_VECTOR;
      flags_r <= 4'd0;
      depth_r <= 3'd0;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      flags_r <= flags_s;
      depth_r <= depth_s;
      ack_r   <= ack_s;
    end
  end

  // Save stack: entry holds {return PC, NZCV}; contents need no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_r[depth_r[1:0]] <= {pc_r + 16'd1, flags_r};
    end
  end

  assign pc_out    = pc_r;
  assign flags_q   = flags_r;
  assign isr_depth = depth_r;
  assign irq_ack   = ack_r & ~stall;

endmodule
